// File: rtl/data_mem_loader_pkg.sv
// Shared definitions for the data-memory preload stage.
// Holds the default data and address widths, the derived memory depth, and
// the loader FSM state encoding.
package data_mem_loader_pkg;

  localparam int unsigned W_DEFAULT  = 8;
  localparam int unsigned AW_DEFAULT = 8;
  localparam int unsigned DEPTH      = 2 ** AW_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_loader_if.sv
// Bus bundle for data_mem_loader.
// Groups the load control (start/base_addr/length), the upstream byte
// stream (in_valid/in_data/in_ready), the CPU load/store port, the memory
// write port and the status outputs (busy/done/checksum).
//   master : host/CPU side (drives control, stream and CPU port)
//   slave  : the loader (drives in_ready, memory port and status)
interface data_mem_loader_if
  import data_mem_loader_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) ();

  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [W-1:0]  cpu_wdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          busy;
  logic          done;
  logic [W-1:0]  checksum;

  modport master (
    output start, base_addr, length, in_valid, in_data,
    output cpu_we, cpu_addr, cpu_wdata,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
  );

  modport slave (
    input  start, base_addr, length, in_valid, in_data,
    input  cpu_we, cpu_addr, cpu_wdata,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
  );

endinterface

// File: rtl/data_mem_port_mux.sv
// Memory write-port select for the data-memory preload stage.
// When sel_loader_i is high the loader owns the port; otherwise the CPU
// load/store signals pass straight through. Purely combinational.
//   sel_loader_i            : loader owns the port
//   ld_we_i/ld_addr_i/ld_wdata_i    : loader write request
//   cpu_we_i/cpu_addr_i/cpu_wdata_i : CPU load/store request
//   mem_we_o/mem_addr_o/mem_wdata_o : to memory WriteEn/DataAddress/DataIn
module data_mem_port_mux
  import data_mem_loader_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          sel_loader_i,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [W-1:0]  ld_wdata_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [W-1:0]  cpu_wdata_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [W-1:0]  mem_wdata_o
);

  assign mem_we_o    = sel_loader_i ? ld_we_i    : cpu_we_i;
  assign mem_addr_o  = sel_loader_i ? ld_addr_i  : cpu_addr_i;
  assign mem_wdata_o = sel_loader_i ? ld_wdata_i : cpu_wdata_i;

endmodule

// File: rtl/data_mem_loader.sv
// Preload stage upstream of the data memory.
// A start pulse latches base_addr/length; bytes accepted on the upstream
// valid/ready stream are written to consecutive (wrapping) addresses, one
// per cycle, while busy tells the CPU to stall. done pulses for one cycle at
// the end and checksum holds the mod-2**W sum of the accepted bytes.
//   clk, reset : clock, synchronous active-high reset
//   bus        : data_mem_loader_if slave (control, stream, CPU port,
//                memory port, busy/done/checksum)
module data_mem_loader
  import data_mem_loader_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_loader_if.slave   bus
);

  state_e        state_q;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [W-1:0]  csum_q;
  logic [W-1:0]  csum_d;
  logic          in_ready_q;
  logic          busy_q;
  logic          done_q;

  logic          xfer;
  logic [AW-1:0] ld_addr;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;

  // Reset is synchronous, so the FSM is still in LOAD during the reset cycle;
  // gating here keeps that cycle from writing memory.
  assign xfer    = bus.in_valid && in_ready_q && !reset;
  assign count_d = count_q + 1'b1;
  assign csum_d  = csum_q + bus.in_data;
  // Address arithmetic wraps naturally at AW bits.
  assign ld_addr = base_q + count_q[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      csum_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            count_q <= '0;
            csum_q  <= '0;
            if (bus.length != '0) begin
              base_q     <= bus.base_addr;
              len_q      <= bus.length;
              state_q    <= ST_LOAD;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            count_q <= count_d;
            csum_q  <= csum_d;
            if (count_d == len_q) begin
              state_q    <= ST_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // busy_q is high exactly in LOAD, so it doubles as the port-owner select.
  data_mem_port_mux #(
    .W  (W),
    .AW (AW)
  ) u_port_mux (
    .sel_loader_i (busy_q),
    .ld_we_i      (xfer),
    .ld_addr_i    (ld_addr),
    .ld_wdata_i   (bus.in_data),
    .cpu_we_i     (bus.cpu_we),
    .cpu_addr_i   (bus.cpu_addr),
    .cpu_wdata_i  (bus.cpu_wdata),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata)
  );

  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.in_ready  = in_ready_q && !reset;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.checksum  = csum_q;

endmodule

// File: tb/tb_data_mem_loader.sv
module tb_data_mem_loader;

  localparam int unsigned NONE = 32'hFFFF_FFFF;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic reset;

  data_mem_loader_if #(.W(8), .AW(8)) bus ();

  data_mem_loader #(.W(8), .AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_bad;
  wr_t         exp_q[$];
  logic [7:0]  pat[$];
  int unsigned busy_cycles;
  int unsigned done_cnt;
  int unsigned wr_cnt[256];
  wr_t         mon_e;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every loader-owned write must match the next expected one.
  always @(negedge clk) begin
    if (bus.busy) busy_cycles++;
    if (bus.done) done_cnt++;
    if (bus.mem_we && bus.busy) begin
      wr_cnt[bus.mem_addr]++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_wr", {24'd0, bus.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wr_addr", {24'd0, bus.mem_addr}, {24'd0, mon_e.addr});
        check_val("wr_data", {24'd0, bus.mem_wdata}, {24'd0, mon_e.data});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Offer one byte; returns #1 after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] addr, input logic [7:0] data, input string tag);
    int unsigned guard;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    exp_q.push_back('{addr: addr, data: data});
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check_val({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] base, input int unsigned len, input int unsigned gap,
                          input int unsigned restart_at, input string tag);
    logic [7:0]  exp_sum;
    logic [7:0]  a;
    int unsigned done0;
    exp_sum = '0;
    @(posedge clk);
    #1;
    busy_cycles   = 0;
    done0         = done_cnt;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = 9'(len);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int unsigned i = 0; i < len; i++) begin
      if (i == restart_at) begin
        bus.start     = 1'b1;
        bus.base_addr = 8'h99;
        bus.length    = 9'd7;
      end
      a = base + 8'(i);
      exp_sum += pat[i];
      send_byte(a, pat[i], tag);
      bus.start = 1'b0;
      if (i + 1 < len) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check_val({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check_val({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check_val({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
    check_val({tag, "_csum"}, {24'd0, bus.checksum}, {24'd0, exp_sum});
    check_val({tag, "_pending"}, exp_q.size(), 32'd0);
    check_val({tag, "_done_cnt"}, done_cnt - done0, 32'd1);
    check_val({tag, "_busy_cycles"}, busy_cycles, len + gap * (len - 1));
  endtask

  initial begin
    int unsigned bad_addrs;
    n_cmp = 0;
    n_bad = 0;
    busy_cycles = 0;
    done_cnt = 0;
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_csum", {24'd0, bus.checksum}, 32'd0);
    check_val("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    pat = {8'h01, 8'h02, 8'h03, 8'h04};
    run_load(8'h10, 4, 0, NONE, "basic");
    run_load(8'h10, 4, 3, NONE, "gaps");

    pat = {8'hFF, 8'hFF, 8'h01, 8'h00};
    run_load(8'hFE, 4, 0, NONE, "wrap");

    // Zero length: done next cycle, checksum cleared, nothing written.
    @(posedge clk);
    #1;
    done_cnt      = 0;
    bus.start     = 1'b1;
    bus.base_addr = 8'h55;
    bus.length    = 9'd0;
    @(negedge clk);
    check_val("zero_no_done_early", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_val("zero_done", {31'd0, bus.done}, 32'd1);
    check_val("zero_busy", {31'd0, bus.busy}, 32'd0);
    check_val("zero_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check_val("zero_csum", {24'd0, bus.checksum}, 32'd0);
    @(negedge clk);
    check_val("zero_done_cnt", done_cnt, 32'd1);

    // Full length from 0x80: every address written exactly once.
    pat.delete();
    for (int unsigned i = 0; i < 256; i++) pat.push_back(8'(i * 7 + 3));
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    run_load(8'h80, 256, 0, NONE, "full");
    bad_addrs = 0;
    foreach (wr_cnt[i]) if (wr_cnt[i] != 1) bad_addrs++;
    check_val("full_cover", bad_addrs, 32'd0);

    // CPU isolation: a CPU store to 0x20 held across a load with gaps.
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 8'h20;
    bus.cpu_wdata = 8'h5A;
    pat = {8'hA1, 8'hA2, 8'hA3};
    run_load(8'h40, 3, 2, NONE, "cpu_iso");
    check_val("cpu_pass_we", {31'd0, bus.mem_we}, 32'd1);
    check_val("cpu_pass_addr", {24'd0, bus.mem_addr}, 32'h20);
    check_val("cpu_pass_data", {24'd0, bus.mem_wdata}, 32'h5A);
    bus.cpu_we = 1'b0;

    // Start during LOAD is ignored.
    pat = {8'h11, 8'h22, 8'h33};
    run_load(8'h60, 3, 0, 1, "restart");

    // Reset after byte 2 of 5.
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = 8'h30;
    bus.length    = 9'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    send_byte(8'h30, 8'h10, "midrst");
    send_byte(8'h31, 8'h20, "midrst");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    reset        = 1'b1;
    @(negedge clk);
    check_val("midrst_we_in_reset", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check_val("midrst_ready", {31'd0, bus.in_ready}, 32'd0);
      check_val("midrst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check_val("midrst_csum", {24'd0, bus.checksum}, 32'd0);
    end
    bus.in_valid = 1'b0;
    check_val("final_pending", exp_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_loader.md
Name: data_mem_loader

Overview:
- Preload stage sitting directly upstream of the data memory. It streams bytes from a test/host interface into consecutive data-memory addresses before or between program runs.
- Owns the memory write port while loading. Otherwise passes the CPU's load/store signals through unchanged.
- Keeps a running 8-bit checksum of loaded bytes so the bench and host can confirm image integrity.

Parameters:
- W, 8, data width in bits (matches the memory word).
- AW, 8, address width; memory depth is 2**AW bytes.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load using base_addr/length
- base_addr  input  AW  first memory address written
- length  input  AW+1  byte count to load, 0..2**AW
- in_valid  input  1  upstream byte valid
- in_data  input  W  upstream byte
- in_ready  output  1  loader accepts a byte this cycle
- cpu_we  input  1  CPU store enable
- cpu_addr  input  AW  CPU load/store address
- cpu_wdata  input  W  CPU store data
- mem_we  output  1  to memory WriteEn
- mem_addr  output  AW  to memory DataAddress
- mem_wdata  output  W  to memory DataIn
- busy  output  1  load in progress; CPU must stall
- done  output  1  one-cycle pulse when a load completes
- checksum  output  W  mod-2**W sum of bytes accepted in the current/last load

Behaviour:
- FSM states are IDLE, LOAD, DONE. Reset forces IDLE, clears count and checksum, and drives in_ready=0, busy=0, done=0.
- IDLE, start=1, length>0:
  - Latch base_addr and length.
  - Clear count and checksum.
  - Go to LOAD next cycle.
- IDLE, start=1, length=0: go to DONE and clear checksum; nothing is written.
- LOAD:
  - in_ready=1 and busy=1.
  - A transfer occurs when in_valid && in_ready in the same cycle. That cycle combinationally drives mem_we=1, mem_addr=(base+count) mod 2**AW, mem_wdata=in_data.
  - On the clock edge of a transfer: count+=1, checksum+=in_data (wraps mod 2**W).
  - When the accepted byte is the last one (count+1==length), go to DONE; in_ready falls in the next cycle.
  - in_valid=0 in LOAD: mem_we=0, mem_addr=(base+count), and the FSM stays in LOAD indefinitely.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Address wrap: base+count beyond 2**AW-1 wraps to 0. length=2**AW from any base writes every location exactly once.
- start while in LOAD or DONE is ignored; latched parameters do not change.
- CPU pass-through:
  - In IDLE and DONE, mem_we/mem_addr/mem_wdata equal cpu_we/cpu_addr/cpu_wdata combinationally.
  - In LOAD, CPU signals are ignored and cpu_we never reaches memory. The CPU observes busy and stalls.
- Checksum holds its final value after DONE until the next accepted start or reset.
- Reset mid-LOAD: FSM returns to IDLE the next cycle with no further writes. Bytes already written stay written; the memory's own reset clears them only if it is asserted too.
- Latency: one byte per cycle sustained. Zero-cycle combinational path from in_data to mem_wdata. The memory commits each write on the same edge that the loader advances count.

Decomposition:
- Shared package holds:
  - W and AW defaults.
  - The state enum (IDLE, LOAD, DONE).
  - DEPTH = 2**AW.
- The memory-port output mux (loader vs CPU select) is a natural small sub-module, data_mem_port_mux. The FSM, counter and checksum stay in data_mem_loader.

Test Plan:
- Basic load:
  - Stimulus: reset, then start with base=0x10, length=4, bytes 0x01,0x02,0x03,0x04 back-to-back.
  - Response: writes to 0x10..0x13, done pulses once, checksum=0x0A, busy high for exactly 4 cycles.
- Upstream gaps: same load with in_valid deasserted 3 cycles between bytes -> no mem_we during gaps, addresses still contiguous, same checksum.
- Wrap:
  - Stimulus: base=0xFE, length=4, bytes 0xFF,0xFF,0x01,0x00.
  - Response: addresses 0xFE,0xFF,0x00,0x01; checksum=0xFF.
- Zero length and full length:
  - length=0: done the cycle after start, no mem_we.
  - length=256 from base=0x80: 256 writes covering all addresses once.
- CPU isolation:
  - Stimulus: assert cpu_we with cpu_addr=0x20 during LOAD.
  - Response: no write to 0x20; in IDLE the same request passes through and mem_we=1, mem_addr=0x20.
- Reset mid-load and ignored start:
  - Assert reset after byte 2 of 5 -> IDLE, busy=0, checksum=0, no further writes.
  - start during LOAD does not restart the count.
